// File: rtl/flt2int_pkg.sv
// Shared types and constants for the half-precision float to sign-magnitude integer converter.
package flt2int_pkg;

  localparam int unsigned EXP_W = 5;
  localparam int unsigned MAN_W = 10;
  localparam int unsigned MAG_W = 15;
  localparam int unsigned SIG_W = MAN_W + 1;
  localparam int unsigned CNT_W = 5;

  localparam logic [EXP_W-1:0] BIAS        = 5'd15;
  localparam logic [EXP_W-1:0] SHIFT_PIVOT = BIAS + EXP_W'(MAN_W);
  localparam logic [EXP_W-1:0] SAT_EXP     = 5'd30;
  localparam logic [EXP_W-1:0] MIN_EXP     = 5'd14;
  localparam logic [MAG_W-1:0] MAG_MAX     = 15'h7FFF;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_HI,
    ST_RD_LO,
    ST_CAPT,
    ST_CLASS,
    ST_SHIFT,
    ST_ROUND,
    ST_WR_HI,
    ST_WR_LO,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    PATH_ZERO,
    PATH_SAT,
    PATH_RIGHT,
    PATH_LEFT
  } path_t;

endpackage

// File: rtl/flt2int_unpack.sv
// Combinational classifier: splits a half float into sign/significand and picks
// the conversion path plus the number of one-bit shift steps.
module flt2int_unpack
  import flt2int_pkg::*;
(
  input  logic [15:0]      i_flt,
  output logic             o_sign,
  output logic [SIG_W-1:0] o_sig,
  output path_t            o_path,
  output logic [CNT_W-1:0] o_n,
  output logic             o_sat,
  output logic             o_flush_inexact
);

  logic [EXP_W-1:0] w_exp;
  logic [MAN_W-1:0] w_man;

  assign w_exp  = i_flt[14:10];
  assign w_man  = i_flt[9:0];
  assign o_sign = i_flt[15];
  assign o_sig  = {1'b1, w_man};

  always_comb begin
    o_path          = PATH_ZERO;
    o_n             = '0;
    o_sat           = 1'b0;
    o_flush_inexact = 1'b0;
    if (w_exp >= SAT_EXP) begin
      o_path = PATH_SAT;
      o_sat  = 1'b1;
    end else if (w_exp < MIN_EXP) begin
      // Covers zero, subnormals and |x| < 0.5; only an all-zero encoding is exact.
      o_path          = PATH_ZERO;
      o_flush_inexact = (w_exp != '0) || (w_man != '0);
    end else if (w_exp < SHIFT_PIVOT) begin
      o_path = PATH_RIGHT;
      o_n    = CNT_W'(SHIFT_PIVOT - w_exp);
    end else begin
      o_path = PATH_LEFT;
      o_n    = CNT_W'(w_exp - SHIFT_PIVOT);
    end
  end

endmodule

// File: rtl/flt2int.sv
// Sequential half-float to 16-bit sign-magnitude converter acting as a memory bus master.
// Optional ovf/inexact flag ports are enabled by defining FLT2INT_FLAGS_EN.
module flt2int
  import flt2int_pkg::*;
#(
  parameter logic [7:0] SRC_ADDR = 8'd5,
  parameter logic [7:0] DST_ADDR = 8'd3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [7:0] mem_addr,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata
`ifdef FLT2INT_FLAGS_EN
  ,
  output logic       ovf,
  output logic       inexact
`endif
);

  state_t           r_state;
  logic [15:0]      r_flt;
  logic [MAG_W-1:0] r_val;
  logic             r_guard;
  logic             r_sticky;
  logic [CNT_W-1:0] r_n;
  path_t            r_path;
  logic             r_sign;
  logic             r_busy;
  logic             r_done;
  logic [7:0]       r_addr;
  logic             r_rd;
  logic             r_wr;
  logic [7:0]       r_wdata;
  logic             r_ovf;
  logic             r_inexact;

  logic             w_sign;
  logic [SIG_W-1:0] w_sig;
  path_t            w_path;
  logic [CNT_W-1:0] w_n;
  logic             w_sat;
  logic             w_flush_inexact;
  logic             w_round_up;
  logic [MAG_W-1:0] w_mag;

  flt2int_unpack u_unpack (
    .i_flt           (r_flt),
    .o_sign          (w_sign),
    .o_sig           (w_sig),
    .o_path          (w_path),
    .o_n             (w_n),
    .o_sat           (w_sat),
    .o_flush_inexact (w_flush_inexact)
  );

  // Round-to-nearest-even only matters after right shifts; other paths are exact or fixed.
  assign w_round_up = (r_path == PATH_RIGHT) && r_guard && (r_sticky || r_val[0]);
  assign w_mag      = r_val + MAG_W'(w_round_up);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_flt     <= '0;
      r_val     <= '0;
      r_guard   <= 1'b0;
      r_sticky  <= 1'b0;
      r_n       <= '0;
      r_path    <= PATH_ZERO;
      r_sign    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_addr    <= '0;
      r_rd      <= 1'b0;
      r_wr      <= 1'b0;
      r_wdata   <= '0;
      r_ovf     <= 1'b0;
      r_inexact <= 1'b0;
    end else begin
      r_rd <= 1'b0;
      r_wr <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state   <= ST_RD_HI;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
            r_rd      <= 1'b1;
            r_addr    <= SRC_ADDR;
            r_ovf     <= 1'b0;
            r_inexact <= 1'b0;
          end
        end
        ST_RD_HI: begin
          r_state <= ST_RD_LO;
          r_rd    <= 1'b1;
          r_addr  <= SRC_ADDR + 8'd1;
        end
        ST_RD_LO: begin
          r_flt[15:8] <= mem_rdata;
          r_state     <= ST_CAPT;
        end
        ST_CAPT: begin
          r_flt[7:0] <= mem_rdata;
          r_state    <= ST_CLASS;
        end
        ST_CLASS: begin
          r_sign    <= w_sign;
          r_path    <= w_path;
          r_n       <= w_n;
          r_guard   <= 1'b0;
          r_sticky  <= 1'b0;
          r_ovf     <= w_sat;
          r_inexact <= w_sat || w_flush_inexact;
          case (w_path)
            PATH_SAT:  r_val <= MAG_MAX;
            PATH_ZERO: r_val <= '0;
            default:   r_val <= {{(MAG_W-SIG_W){1'b0}}, w_sig};
          endcase
          r_state <= (w_n == '0) ? ST_ROUND : ST_SHIFT;
        end
        ST_SHIFT: begin
          if (r_path == PATH_RIGHT) begin
            r_val    <= r_val >> 1;
            r_guard  <= r_val[0];
            r_sticky <= r_sticky || r_guard;
          end else begin
            r_val <= r_val << 1;
          end
          r_n <= r_n - 1'b1;
          if (r_n == CNT_W'(1)) r_state <= ST_ROUND;
        end
        ST_ROUND: begin
          r_val   <= w_mag;
          r_wr    <= 1'b1;
          r_addr  <= DST_ADDR;
          r_wdata <= {r_sign, w_mag[14:8]};
          if (r_path == PATH_RIGHT && (r_guard || r_sticky)) r_inexact <= 1'b1;
          r_state <= ST_WR_HI;
        end
        ST_WR_HI: begin
          r_wr    <= 1'b1;
          r_addr  <= DST_ADDR + 8'd1;
          r_wdata <= r_val[7:0];
          r_state <= ST_WR_LO;
        end
        ST_WR_LO: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= ST_DONE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign mem_addr  = r_addr;
  assign mem_rd    = r_rd;
  assign mem_wr    = r_wr;
  assign mem_wdata = r_wdata;

`ifdef FLT2INT_FLAGS_EN
  assign ovf     = r_ovf;
  assign inexact = r_inexact;
`else
  logic w_flags_unused;
  assign w_flags_unused = r_ovf ^ r_inexact;
`endif

endmodule

// File: tb/tb_flt2int.sv
// Self-checking bench for flt2int: directed cases pinned to literals plus random floats
// checked against an arithmetic reference model.
module tb_flt2int;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       busy;
  logic       done;
  logic [7:0] mem_addr;
  logic       mem_rd;
  logic       mem_wr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
`ifdef FLT2INT_FLAGS_EN
  logic       ovf;
  logic       inexact;
`endif

  flt2int #(.SRC_ADDR(8'd5), .DST_ADDR(8'd3)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
`ifdef FLT2INT_FLAGS_EN
    ,
    .ovf       (ovf),
    .inexact   (inexact)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Memory with registered read; bench pokes go through the same port when the DUT is not writing.
  logic [7:0] mem [0:255];
  logic       tb_we = 1'b0;
  logic [7:0] tb_waddr = '0;
  logic [7:0] tb_wdata = '0;
  int         dst_writes = 0;

  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem[mem_addr];
    if (mem_wr) begin
      mem[mem_addr] <= mem_wdata;
      if (mem_addr == 8'd3 || mem_addr == 8'd4) dst_writes <= dst_writes + 1;
    end else if (tb_we) begin
      mem[tb_waddr] <= tb_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: value = sig * 2^(e-25), rounded to nearest with ties to even.
  task automatic model(input logic [15:0] f, output logic [15:0] res, output int cyc,
                       output bit m_ovf, output bit m_inex);
    int e;
    longint sig, den, q, r;
    e      = int'(f[14:10]);
    sig    = 1024 + longint'(f[9:0]);
    m_ovf  = 1'b0;
    m_inex = 1'b0;
    cyc    = 7;
    if (e >= 30) begin
      q = 32767; m_ovf = 1'b1; m_inex = 1'b1;
    end else if (e == 0) begin
      q = 0; m_inex = (f[9:0] != 0);
    end else if (e >= 25) begin
      q = sig << (e - 25); cyc = 7 + (e - 25);
    end else begin
      den = longint'(1) << (25 - e);
      q = sig / den;
      r = sig % den;
      if (2 * r > den || (2 * r == den && q % 2 == 1)) q = q + 1;
      m_inex = (r != 0);
      if (e >= 14) cyc = 7 + (25 - e);
    end
    res = {f[15], 15'(q)};
  endtask

  logic [15:0] exp_res;
  bit          exp_ovf;
  bit          exp_inex;
  bit          chk_en = 1'b0;

  // Per-cycle compare process: bus exclusivity always, result bytes and flags while done.
  always @(negedge clk) begin
    if (!reset) begin
      chk("rd_wr_exclusive", 32'(mem_rd && mem_wr), 32'd0);
      if (!mem_rd && !mem_wr && !busy) chk("bus_idle_when_not_busy", 32'(mem_rd | mem_wr), 32'd0);
    end
    if (chk_en && done) begin
      chk("result", {16'd0, mem[3], mem[4]}, {16'd0, exp_res});
`ifdef FLT2INT_FLAGS_EN
      chk("ovf", 32'(ovf), 32'(exp_ovf));
      chk("inexact", 32'(inexact), 32'(exp_inex));
`endif
    end
  end

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    tb_we = 1'b1; tb_waddr = a; tb_wdata = d;
    @(posedge clk);
    #1 tb_we = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 60) begin
      @(posedge clk);
      #1 cyc++;
    end
    if (!done) chk("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic run_conv(input logic [15:0] f);
    int exp_cyc, cyc;
    logic [15:0] r;
    bit o, ix;
    chk_en = 1'b0;
    model(f, r, exp_cyc, o, ix);
    exp_res = r; exp_ovf = o; exp_inex = ix;
    poke(8'd5, f[15:8]);
    poke(8'd6, f[7:0]);
    poke(8'd3, 8'h5A);
    poke(8'd4, 8'hA5);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    wait_done(cyc);
    chk("latency", cyc, exp_cyc);
    chk("busy_at_done", 32'(busy), 32'd0);
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b0;
  endtask

  typedef struct {
    logic [15:0] f;
    logic [15:0] res;
    int          cyc;
  } vec_t;

  vec_t vecs[$] = '{
    '{16'h3C00, 16'h0001, 17}, '{16'hC500, 16'h8005, 15}, '{16'h3E00, 16'h0002, 17},
    '{16'h4100, 16'h0002, 16}, '{16'h3800, 16'h0000, 18}, '{16'h77FF, 16'h7FF0, 11},
    '{16'h7800, 16'h7FFF, 7},  '{16'hFC00, 16'hFFFF, 7},  '{16'h0001, 16'h0000, 7},
    '{16'h8000, 16'h8000, 7}
  };

  initial begin
    logic [15:0] r, f;
    int c, cyc;
    bit o, ix;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {22'd0, busy, done, mem_rd, mem_wr, mem_addr}, 32'd0);
    chk("reset_wdata", 32'(mem_wdata), 32'd0);
    reset = 1'b0;

    // Pin the model to hand-computed values, then run each case on the DUT.
    foreach (vecs[i]) begin
      model(vecs[i].f, r, c, o, ix);
      chk("model_pin_res", {16'd0, r}, {16'd0, vecs[i].res});
      chk("model_pin_cyc", c, vecs[i].cyc);
      run_conv(vecs[i].f);
    end
    model(16'hFC00, r, c, o, ix);
    chk("model_pin_ovf", 32'(o), 32'd1);
    model(16'h0001, r, c, o, ix);
    chk("model_pin_inexact", 32'(ix), 32'd1);

    for (int i = 0; i < 150; i++) begin
      f = 16'($urandom);
      if (i % 2 == 0) f[14:10] = 5'($urandom_range(10, 29));
      run_conv(f);
    end

    // Reset during SHIFT of 1.0: no destination write, outputs clear, next run correct.
    poke(8'd5, 8'h3C);
    poke(8'd6, 8'h00);
    poke(8'd3, 8'hA5);
    poke(8'd4, 8'hA5);
    c = dst_writes;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_outputs", {22'd0, busy, done, mem_rd, mem_wr, mem_addr}, 32'd0);
    chk("abort_wdata", 32'(mem_wdata), 32'd0);
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("abort_no_write", dst_writes - c, 0);
    chk("abort_mem", {16'd0, mem[3], mem[4]}, 32'h0000A5A5);
    run_conv(16'h3C00);

    // Back-to-back: start held through DONE restarts immediately.
    poke(8'd5, 8'h3C);
    poke(8'd6, 8'h00);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1;
    repeat (4) @(posedge clk);
    poke(8'd5, 8'hC5);
    poke(8'd6, 8'h00);
    wait_done(cyc);
    chk("b2b_first", {16'd0, mem[3], mem[4]}, 32'h00000001);
    @(posedge clk);
    #1;
    chk("b2b_restart", {30'd0, done, busy}, 32'd1);
    start = 1'b0;
    wait_done(cyc);
    chk("b2b_second", {16'd0, mem[3], mem[4]}, 32'h00008005);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/flt2int.md
Name: flt2int

Overview:
- Sequential float-to-integer converter; the inverse of the team's integer-to-float block.
- Reads a 16-bit float from data memory as two bytes. Float format: [15] sign, [14:10] exponent with bias 15, [9:0] mantissa with hidden 1.
- Converts it to 16-bit sign-magnitude: [15] sign, [14:0] magnitude. Rounding is round-to-nearest-even.
- Writes the two result bytes back to memory. Acts as a bus master on the shared 8-bit data memory port; the top-level test harness starts it with start/done.

Parameters:
- SRC_ADDR, 8'd5, address of float high byte; low byte at SRC_ADDR+1.
- DST_ADDR, 8'd3, address of integer high byte; low byte at DST_ADDR+1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin conversion; sampled only in IDLE
- busy  out  1  high from start acceptance until done rises
- done  out  1  level; high from DONE until the next start is accepted
- mem_addr  out  8  data memory address
- mem_rd  out  1  read strobe; mem_rdata is valid the cycle after
- mem_wr  out  1  write strobe; memory writes mem_wdata at posedge
- mem_wdata  out  8  write data
- mem_rdata  in  8  read data, registered in memory (1-cycle latency)

Behaviour:
- Reset (synchronous, active-high; clock clk): state=IDLE; busy=0, done=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0. Internal regs are cleared.
- Reset mid-operation aborts the conversion. No further memory writes occur; a partial write may already have landed.
- States: IDLE, RD_HI, RD_LO, CAPT, CLASS, SHIFT, ROUND, WR_HI, WR_LO, DONE.
- IDLE (also DONE) with start=1 -> RD_HI. busy rises, done falls. start held high in DONE restarts the block.
- RD_HI: mem_rd=1, mem_addr=SRC_ADDR.
- RD_LO: mem_rd=1, mem_addr=SRC_ADDR+1; capture the high byte.
- CAPT: capture the low byte.
- CLASS: unpack s, e, m and set the result path (sig = {1,m}, 11 bits):
  - e=0 (zero/subnormal): mag=0, n=0.
  - e>=30, including e=31 inf/NaN: mag=15'h7FFF (saturate), n=0.
  - e<=13: mag=0, n=0 (|x|<0.5).
  - 14<=e<=24: right-shift path, n=25-e.
  - 25<=e<=29: left-shift path, n=e-25.
- SHIFT: one bit per cycle, n cycles; skipped when n=0.
  - Right shifts track guard (last bit shifted out) and sticky (OR of all earlier shifted-out bits).
  - Left shifts insert 0.
- ROUND: add 1 if guard & (sticky | lsb). Applies to the right-shift path only. No carry beyond bit 11 is possible.
- WR_HI: mem_wr=1, mem_addr=DST_ADDR, mem_wdata={s, mag[14:8]}.
- WR_LO: mem_wr=1, mem_addr=DST_ADDR+1, mem_wdata=mag[7:0].
- DONE: done=1, busy=0.
- The sign bit is always copied from the input, including zero magnitude and saturation: -0.0 -> 16'h8000.
- Latency: done is high in the cycle following edge k+7+n, where k is the start-sampling edge.
- mem_rd and mem_wr are never high together. Both are low outside the RD and WR states.

Optional Feature:
- FLT2INT_FLAGS_EN defined:
  - Adds output ports ovf (1) and inexact (1). Both are valid while done=1 and cleared on start acceptance and on reset.
  - ovf=1 on the saturate path (e>=30).
  - inexact=1 on saturate, or when guard|sticky is nonzero at ROUND, or on nonzero mantissa/exponent flushed to 0 (e=0 with m!=0, or 1<=e<=13).
- Undefined: ports absent; behaviour otherwise identical, with the same cycle counts.

Decomposition:
- flt2int_pkg holds:
  - state enum (state_t);
  - field widths (EXP_W=5, MAN_W=10, MAG_W=15);
  - constants: BIAS=15, SHIFT_PIVOT=25, SAT_EXP=30, MIN_EXP=14, MAG_MAX=15'h7FFF.
- One sub-module, flt2int_unpack: combinational classifier taking the 16-bit float and producing s, sig, path select, n and the special flags. The FSM and datapath stay in flt2int.

Test Plan:
- 16'h3C00 (1.0) at SRC -> mem[3]=8'h00, mem[4]=8'h01; done high 17 cycles after start (n=10).
- 16'hC500 (-5.0) -> 16'h8005; 16'h3E00 (1.5) -> 16'h0002; 16'h4100 (2.5) -> 16'h0002 (tie-to-even); 16'h3800 (0.5) -> 16'h0000.
- 16'h77FF -> 16'h7FF0 in 11 cycles (n=4); 16'h7800 -> 16'h7FFF; 16'hFC00 (-inf) -> 16'hFFFF, with ovf=1 under FLT2INT_FLAGS_EN.
- 16'h0001 (subnormal) -> 16'h0000 (inexact=1 with flags); 16'h8000 -> 16'h8000; each completes in 7 cycles.
- Reset asserted during SHIFT of a 1.0 conversion -> no write to mem[3]/mem[4]; all outputs 0 next cycle; a following start converts correctly.
- Back-to-back: start held high across DONE -> second conversion begins the next cycle; mem_rd and mem_wr are never simultaneously high (assertion).
